// File: rtl/wb_axi_bridge.sv
// wb_axi_bridge: Wishbone classic slave to AXI-Lite master / AXI-Stream bridge
// with an output-stream prefetch FIFO, a sticky status register and a stall timeout.
module wb_axi_bridge #(
    parameter int pADDR_WIDTH   = 12,
    parameter int pDATA_WIDTH   = 32,
    parameter int STREAM_LEN    = 64,
    parameter int SM_FIFO_DEPTH = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [pDATA_WIDTH/8-1:0] wbs_sel_i,
    input  logic [pDATA_WIDTH-1:0]   wbs_dat_i,
    input  logic [31:0]              wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic [pDATA_WIDTH-1:0]   wbs_dat_o,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [pADDR_WIDTH-1:0]   awaddr,
    output logic                     wvalid,
    input  logic                     wready,
    output logic [pDATA_WIDTH-1:0]   wdata,
    output logic [pDATA_WIDTH/8-1:0] wstrb,
    output logic                     arvalid,
    input  logic                     arready,
    output logic [pADDR_WIDTH-1:0]   araddr,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [pDATA_WIDTH-1:0]   rdata,
    output logic                     ss_tvalid,
    input  logic                     ss_tready,
    output logic [pDATA_WIDTH-1:0]   ss_tdata,
    output logic                     ss_tlast,
    input  logic                     sm_tvalid,
    output logic                     sm_tready,
    input  logic [pDATA_WIDTH-1:0]   sm_tdata,
    input  logic                     sm_tlast
);
    localparam int FA = $clog2(SM_FIFO_DEPTH);
    localparam int BW = STREAM_LEN > 1 ? $clog2(STREAM_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, AXW, AXR_A, AXR_D, SS, SM_WAIT, ACK} state_t;
    state_t state, nxt;

    logic [pADDR_WIDTH-1:0] a;
    logic                   req, is_axi, is_ss, is_sm, is_st, st_clr, idle_req;
    logic [TW-1:0]          wcnt;
    logic                   to, waiting;
    logic                   aw_done, w_done, aw_hs, w_hs, ar_hs, r_hs, ss_hs;
    logic [BW-1:0]          beat;
    logic                   err, last_seen;
    logic [pDATA_WIDTH:0]   mem [SM_FIFO_DEPTH];
    logic [pDATA_WIDTH:0]   head;
    logic [FA-1:0]          wp, rp;
    logic [FA:0]            cnt, cnt_nxt;
    logic                   empty, full, push, pop;
    logic [pDATA_WIDTH-1:0] status;
    logic                   unused_adr;

    assign unused_adr = ^wbs_adr_i[31:pADDR_WIDTH];
    assign a        = wbs_adr_i[pADDR_WIDTH-1:0];
    assign req      = wbs_stb_i & wbs_cyc_i;
    assign idle_req = state == IDLE && req;
    assign is_axi   = a[7:4] != 4'h8;
    assign is_ss    = a == pADDR_WIDTH'('h80) && wbs_we_i;
    assign is_sm    = a == pADDR_WIDTH'('h84) && !wbs_we_i;
    assign is_st    = a == pADDR_WIDTH'('h88);
    assign st_clr   = idle_req && is_st && wbs_we_i;

    // Valids and readies are Moore decodes of the state, masked in the timeout cycle.
    assign waiting   = state inside {AXW, AXR_A, AXR_D, SS, SM_WAIT};
    assign to        = waiting && wcnt == TW'(TIMEOUT);
    assign awvalid   = state == AXW && !aw_done && !to;
    assign wvalid    = state == AXW && !w_done && !to;
    assign arvalid   = state == AXR_A && !to;
    assign rready    = state == AXR_D && !to;
    assign ss_tvalid = state == SS && !to;
    assign ss_tlast  = ss_tvalid && beat == BW'(STREAM_LEN - 1);
    assign wbs_ack_o = state == ACK;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign ar_hs     = arvalid & arready;
    assign r_hs      = rready & rvalid;
    assign ss_hs     = ss_tvalid & ss_tready;

    assign empty   = cnt == '0;
    assign full    = cnt == (FA+1)'(SM_FIFO_DEPTH);
    assign head    = mem[rp];
    assign push    = sm_tvalid & sm_tready;
    assign pop     = !empty && ((idle_req && is_sm) || (state == SM_WAIT && !to));
    assign cnt_nxt = cnt + {{FA{1'b0}}, push} - {{FA{1'b0}}, pop};

    always_comb begin
        status       = '0;
        status[0]    = err;
        status[1]    = last_seen;
        status[2]    = empty;
        status[3]    = full;
        status[15:8] = 8'(cnt);
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req) nxt = is_axi ? (wbs_we_i ? AXW : AXR_A) :
                                    is_ss ? SS : (is_sm && empty) ? SM_WAIT : ACK;
            AXW:     if (to || ((aw_done || aw_hs) && (w_done || w_hs))) nxt = ACK;
            AXR_A:   nxt = to ? ACK : ar_hs ? AXR_D : AXR_A;
            AXR_D:   if (to || r_hs) nxt = ACK;
            SS:      if (to || ss_hs) nxt = ACK;
            SM_WAIT: if (to || pop) nxt = ACK;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wcnt      <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            beat      <= '0;
            err       <= 1'b0;
            last_seen <= 1'b0;
            wbs_dat_o <= '0;
            awaddr    <= '0;
            araddr    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            ss_tdata  <= '0;
        end else begin
            state     <= nxt;
            wcnt      <= (waiting && nxt == state) ? wcnt + 1'b1 : '0;
            aw_done   <= state == AXW && (aw_done || aw_hs);
            w_done    <= state == AXW && (w_done || w_hs);
            err       <= !st_clr && (err || to);
            last_seen <= !st_clr && (last_seen || (pop && head[pDATA_WIDTH]));
            if (ss_hs) beat <= beat == BW'(STREAM_LEN - 1) ? '0 : beat + 1'b1;
            if (idle_req && is_axi) begin
                awaddr <= a;
                araddr <= a;
                wdata  <= wbs_dat_i;
                wstrb  <= wbs_sel_i;
            end
            if (idle_req && is_ss) ss_tdata <= wbs_dat_i;
            if (to) wbs_dat_o <= '0;
            else if (pop) wbs_dat_o <= head[pDATA_WIDTH-1:0];
            else if (r_hs) wbs_dat_o <= rdata;
            else if (idle_req && !is_axi && !wbs_we_i && !is_sm) wbs_dat_o <= is_st ? status : '0;
        end
    end

    // Registered ready so it stays low through reset and rises on the first clock after.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            sm_tready <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt       <= cnt_nxt;
            sm_tready <= cnt_nxt != (FA+1)'(SM_FIFO_DEPTH);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wp] <= {sm_tlast, sm_tdata};
    end
endmodule

// File: tb/tb_wb_axi_bridge.sv
// tb_wb_axi_bridge: directed vector table plus hand-written sequences for the
// bridge's AXI-Lite, stream, FIFO, timeout and reset behaviour.
`timescale 1ns/1ps
module tb_wb_axi_bridge;
    localparam int TO = 255;

    logic        clk = 1'b0, rst = 1'b1;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, arvalid, arready = 1'b0;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata = '0, ss_tdata, sm_tdata = '0;
    logic [3:0]  wstrb;
    logic        rvalid = 1'b0, rready, ss_tvalid, ss_tready = 1'b1, ss_tlast;
    logic        sm_tvalid = 1'b0, sm_tready, sm_tlast = 1'b0;

    always #5 clk = ~clk;

    wb_axi_bridge dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    int total = 0, bad = 0;
    int aw_d = 0, w_d = 0, ar_d = 0, r_d = 0, aw_c = 0, w_c = 0, ar_c = 0, r_c = 0;
    logic [31:0] rd_val = '0;
    logic tog = 1'b0;
    int aw_hi = 0, w_hi = 0, ack_n = 0, hs = 0, tl_n = 0, tl_at = -1;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, last_ss = '0;
    logic [3:0] cap_wstrb = '0;
    logic last_tl = 1'b0;
    int sm_n = 0, sm_idx = 0;
    logic sm_take = 1'b0;

    // Slave/source models: decide at the falling edge what the next rising edge sees.
    always @(negedge clk) begin
        if (awvalid) begin
            awready = aw_c == aw_d; aw_c++; aw_hi++; cap_awaddr = 32'(awaddr);
        end else begin
            awready = 1'b0; aw_c = 0;
        end
        if (wvalid) begin
            wready = w_c == w_d; w_c++; w_hi++; cap_wdata = wdata; cap_wstrb = wstrb;
        end else begin
            wready = 1'b0; w_c = 0;
        end
        if (arvalid) begin arready = ar_c == ar_d; ar_c++; end
        else begin arready = 1'b0; ar_c = 0; end
        if (rready) begin rvalid = r_c == r_d; rdata = rd_val; r_c++; end
        else begin rvalid = 1'b0; r_c = 0; end
        ss_tready = tog ? ~ss_tready : 1'b1;
        if (ss_tvalid && ss_tready) begin
            hs++; last_tl = ss_tlast; last_ss = ss_tdata;
            if (ss_tlast) begin tl_n++; tl_at = hs - 1; end
        end
        if (wbs_ack_o) ack_n++;
        if (sm_take) sm_idx++;
        sm_tvalid = sm_idx < sm_n;
        sm_tdata  = 32'h100 + 32'(sm_idx);
        sm_tlast  = sm_idx == sm_n - 1;
        sm_take   = sm_tvalid && sm_tready;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One Wishbone cycle; edg is the rising edge (0 = sampling edge E0) at which ack rose.
    task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat, output int edg);
        wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        edg = -1; rdat = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin edg = i; rdat = wbs_dat_o; break; end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        if (edg < 0) begin
            total++; bad++;
            $display("FAIL wb_no_ack adr=%h", adr);
        end
        @(negedge clk);
    endtask

    function automatic logic any_out();
        return |{wbs_ack_o, wbs_dat_o, awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr,
                 rready, ss_tvalid, ss_tdata, ss_tlast, sm_tready};
    endfunction

    typedef struct {
        logic we; logic [31:0] adr, dat; logic [3:0] sel;
        int aw_d, w_d, ar_d, r_d; logic [31:0] rd, exp; int edg; logic cmp;
    } vec_t;
    vec_t v[11];

    logic [31:0] rdat;
    int edg;

    initial begin
        v[0]  = '{1'b0, 32'h88,  32'h0,        4'h0, 0, 0, 0, 0, 32'h0,        32'h4,        0, 1'b1};
        v[1]  = '{1'b1, 32'h04,  32'h11223344, 4'h3, 0, 0, 0, 0, 32'h0,        32'h0,        1, 1'b0};
        v[2]  = '{1'b1, 32'h0C,  32'h55667788, 4'hF, 0, 2, 0, 0, 32'h0,        32'h0,        3, 1'b0};
        v[3]  = '{1'b1, 32'h14,  32'h99AABBCC, 4'hC, 1, 1, 0, 0, 32'h0,        32'h0,        2, 1'b0};
        v[4]  = '{1'b0, 32'h30,  32'h0,        4'hF, 0, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2, 1'b1};
        v[5]  = '{1'b0, 32'h8C,  32'h0,        4'hF, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1'b1};
        v[6]  = '{1'b0, 32'h80,  32'h0,        4'hF, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1'b1};
        v[7]  = '{1'b0, 32'h180, 32'h0,        4'hF, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1'b1};
        v[8]  = '{1'b1, 32'h84,  32'h77,       4'hF, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1'b0};
        v[9]  = '{1'b0, 32'h40,  32'h0,        4'hF, 0, 0, 2, 1, 32'hCAFE0001, 32'hCAFE0001, 5, 1'b1};
        v[10] = '{1'b0, 32'h88,  32'h0,        4'hF, 0, 0, 0, 0, 32'h0,        32'h4,        0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_outs_zero", 32'(any_out()), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("sm_tready_after_reset", 32'(sm_tready), 32'h1);

        foreach (v[k]) begin
            aw_d = v[k].aw_d; w_d = v[k].w_d; ar_d = v[k].ar_d; r_d = v[k].r_d; rd_val = v[k].rd;
            ack_n = 0;
            wb(v[k].we, v[k].adr, v[k].dat, v[k].sel, rdat, edg);
            chk($sformatf("v%0d_ack_edge", k), 32'(edg), 32'(v[k].edg));
            chk($sformatf("v%0d_ack_cycles", k), 32'(ack_n), 32'h1);
            if (v[k].cmp) chk($sformatf("v%0d_rdata", k), rdat, v[k].exp);
        end

        // AXI write, awready 3 cycles late, wready immediate
        aw_d = 3; w_d = 0; aw_hi = 0; w_hi = 0; ack_n = 0;
        wb(1'b1, 32'h10, 32'hA5A50003, 4'hF, rdat, edg);
        chk("axw_ack_edge", 32'(edg), 32'd4);
        chk("axw_awvalid_cycles", 32'(aw_hi), 32'd4);
        chk("axw_wvalid_cycles", 32'(w_hi), 32'd1);
        chk("axw_ack_cycles", 32'(ack_n), 32'd1);
        chk("axw_awaddr", cap_awaddr, 32'h010);
        chk("axw_wstrb", 32'(cap_wstrb), 32'hF);
        chk("axw_wdata", cap_wdata, 32'hA5A50003);
        aw_d = 0;

        // AXI read, data after 2 wait cycles
        ar_d = 0; r_d = 2; rd_val = 32'h1234;
        wb(1'b0, 32'h20, 32'h0, 4'hF, rdat, edg);
        chk("axr_ack_edge", 32'(edg), 32'd4);
        chk("axr_rdata", rdat, 32'h1234);
        r_d = 0;
        wb(1'b0, 32'h88, 32'h0, 4'hF, rdat, edg);
        chk("axr_status_err0", rdat, 32'h4);

        // 65 stream writes with toggling ready
        tog = 1'b1; hs = 0; tl_n = 0; tl_at = -1;
        for (int k = 0; k < 64; k++) wb(1'b1, 32'h80, 32'(k), 4'hF, rdat, edg);
        chk("ss_handshakes", 32'(hs), 32'd64);
        chk("ss_tlast_count", 32'(tl_n), 32'd1);
        chk("ss_tlast_beat", 32'(tl_at), 32'd63);
        chk("ss_last_data", last_ss, 32'd63);
        wb(1'b1, 32'h80, 32'd64, 4'hF, rdat, edg);
        chk("ss_65th_handshake", 32'(hs), 32'd65);
        chk("ss_65th_tlast", 32'(last_tl), 32'h0);
        tog = 1'b0;

        // Accelerator pushes 5 beats while the bus is idle
        sm_n = 5;
        repeat (10) @(negedge clk);
        chk("sm_full_ready_low", 32'(sm_tready), 32'h0);
        wb(1'b0, 32'h88, 32'h0, 4'hF, rdat, edg);
        chk("sm_full_status", rdat, 32'h408);
        for (int k = 0; k < 5; k++) begin
            wb(1'b0, 32'h84, 32'h0, 4'hF, rdat, edg);
            chk($sformatf("sm_pop%0d_data", k), rdat, 32'h100 + 32'(k));
            chk($sformatf("sm_pop%0d_edge", k), 32'(edg), 32'd0);
        end
        wb(1'b0, 32'h88, 32'h0, 4'hF, rdat, edg);
        chk("sm_drained_status", rdat, 32'h6);

        // Pop from an empty FIFO times out
        wb(1'b0, 32'h84, 32'h0, 4'hF, rdat, edg);
        chk("to_ack_edge", 32'(edg), 32'(TO + 1));
        chk("to_rdata", rdat, 32'h0);
        wb(1'b0, 32'h88, 32'h0, 4'hF, rdat, edg);
        chk("to_status_err", rdat, 32'h7);
        wb(1'b1, 32'h88, 32'h0, 4'hF, rdat, edg);
        chk("st_clear_edge", 32'(edg), 32'd0);
        wb(1'b0, 32'h88, 32'h0, 4'hF, rdat, edg);
        chk("st_cleared", rdat, 32'h4);

        // Reset in the middle of an AXI write
        aw_d = 1000;
        wbs_we_i = 1'b1; wbs_adr_i = 32'h10; wbs_dat_i = 32'hFFFF0000; wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_awvalid", 32'(awvalid), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_reset_outs_zero", 32'(any_out()), 32'h0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        aw_d = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_sm_tready", 32'(sm_tready), 32'h1);
        wb(1'b0, 32'h88, 32'h0, 4'hF, rdat, edg);
        chk("mid_status", rdat, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_axi_bridge.md
# wb_axi_bridge

Parametrised Wishbone-slave to AXI bridge for user-project accelerators. Converts single Wishbone classic cycles into AXI-Lite master transactions (configuration/tap space) or AXI-Stream beats (data window). It adds registered handshaking, independent AW/W completion, automatic `ss_tlast` generation, an output-stream prefetch FIFO, a status register and a stall timeout. It sits between the Caravel user Wishbone port and the accelerator (FIR or successor).

## Interface

Parameters:
- `pADDR_WIDTH`, 12: decoded address bits, taken from `wbs_adr_i[pADDR_WIDTH-1:0]`.
- `pDATA_WIDTH`, 32: data width. Must be a multiple of 8.
- `STREAM_LEN`, 64: beats per input frame. `ss_tlast` is asserted on the last beat.
- `SM_FIFO_DEPTH`, 4: output-stream prefetch FIFO depth. Must be a power of 2, ≥2.
- `TIMEOUT`, 255: maximum wait cycles before an error acknowledge.

Ports:
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1 each: Wishbone controls.
- `wbs_sel_i` in pDATA_WIDTH/8: byte selects.
- `wbs_dat_i` in pDATA_WIDTH: write data.
- `wbs_adr_i` in 32: address.
- `wbs_ack_o` out 1: registered acknowledge, one-cycle pulse.
- `wbs_dat_o` out pDATA_WIDTH: registered read data.
- `awvalid` out 1, `awready` in 1, `awaddr` out pADDR_WIDTH: AXI-Lite write address channel.
- `wvalid` out 1, `wready` in 1, `wdata` out pDATA_WIDTH, `wstrb` out pDATA_WIDTH/8: AXI-Lite write data channel.
- `arvalid` out 1, `arready` in 1, `araddr` out pADDR_WIDTH: AXI-Lite read address channel.
- `rvalid` in 1, `rready` out 1, `rdata` in pDATA_WIDTH: AXI-Lite read data channel.
- `ss_tvalid` out 1, `ss_tready` in 1, `ss_tdata` out pDATA_WIDTH, `ss_tlast` out 1: stream to accelerator.
- `sm_tvalid` in 1, `sm_tready` out 1, `sm_tdata` in pDATA_WIDTH, `sm_tlast` in 1: stream from accelerator.

## Operation

- A request is `wbs_stb_i & wbs_cyc_i` sampled in IDLE.
- Address decode uses `a = wbs_adr_i[pADDR_WIDTH-1:0]`:
  - `a[7:4] != 4'h8`: AXI-Lite.
  - `a == 0x80`, write: ss push.
  - `a == 0x84`, read: sm pop.
  - `a == 0x88`: status register.
  - Any other 0x8x address: immediate ack, read data 0, write ignored.
- FSM states:
  - IDLE → AXW (AXI write), AXR_A (AXI read), SS, SM_WAIT, or ACK (status, FIFO hit, or unmapped address).
  - AXW: `awvalid` and `wvalid` are asserted together. Each drops individually after its own handshake. → ACK when both are done.
  - AXR_A: `arvalid` held until handshake, then → AXR_D.
  - AXR_D: `rready=1`. On `rvalid` capture `rdata` into `wbs_dat_o`, → ACK.
  - SS: `ss_tvalid` held until `ss_tready`, → ACK.
  - SM_WAIT: wait until the FIFO is non-empty, pop, → ACK.
  - ACK: `wbs_ack_o=1` for exactly one cycle, → IDLE.
- Address, data and strobe are latched on leaving IDLE. `wstrb = wbs_sel_i`.
- `ss_tlast`: a beat counter counts 0..STREAM_LEN-1. `ss_tlast=1` when the count is STREAM_LEN-1. The counter increments per ss handshake and wraps to 0.
- sm FIFO:
  - `sm_tready = !full`, independent of the FSM.
  - Each entry stores `{tlast, tdata}`.
  - A simultaneous push and pop when full is not permitted, because ready is low. A simultaneous push and pop when non-empty keeps the count unchanged.
- Status word read at 0x88: `[0]` err sticky, `[1]` last_seen sticky (set when a popped entry had tlast), `[2]` fifo empty, `[3]` fifo full, `[15:8]` fifo count, all other bits 0.
- Any write to 0x88 clears err and last_seen.
- Timeout:
  - A wait counter runs in AXW, AXR_A, AXR_D, SS and SM_WAIT. It is cleared on entering each state.
  - When it reaches TIMEOUT: all valids/readies drop, err is set, `wbs_dat_o` = 0, → ACK.
  - The ss beat counter does not advance and the FIFO does not pop on a timeout.
- Reset (any time, including mid-transaction): state IDLE, all outputs 0, FIFO empty, counters 0, err and last_seen 0. After reset deasserts, `sm_tready` goes to 1 on the first clock.

## Timing

- Notation: E0 is the edge where the request is sampled in IDLE.
- AXI write, both readies high: valids high E0–E1, ack high E1–E2. Ack latency is 2 cycles.
- AW and W may complete in either order or the same cycle. Ack follows the later handshake by one cycle.
- AXI read, ready/valid immediate: `arvalid` E0–E1, `rready` E1–E2, data captured at E2, ack E2–E3.
- ss write: ack one cycle after the `ss_tready` handshake.
- sm read with FIFO non-empty at E0: pop at E0, ack and data E0–E1.
- Status read and unmapped addresses: ack E0–E1.
- `wbs_dat_o` is valid only while `wbs_ack_o=1` and holds its value otherwise.
- The next request can be sampled in the cycle after ack, i.e. the IDLE cycle.

## Test plan

- AXI write to 0x10 with data 0xA5A5_0003 and sel 0xF; `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` after 4; single ack; `awaddr=0x010`, `wstrb=0xF`.
- AXI read 0x20, slave returns `rdata=0x1234` after 2 wait cycles → `wbs_dat_o=0x1234` with the one-cycle ack, err=0.
- 64 writes to 0x80 with `ss_tready` toggling → exactly 64 handshakes; `ss_tlast` only on beat 63; a 65th write has `ss_tlast=0`.
- Accelerator pushes 5 beats (the last with tlast) while idle → FIFO holds 4 and `sm_tready=0`. Five 0x84 reads return the beats in order. Status then reads last_seen=1, empty=1.
- 0x84 read with an empty FIFO and no sm traffic → ack exactly TIMEOUT+1 cycles after E0, data 0. Status bit0=1; a write to 0x88 clears it.
- Assert `wb_rst_i` while in AXW with `awvalid` high → all outputs 0 immediately. After release, a status read returns empty=1, err=0.
